// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives a single-outstanding
// request/ack instruction-memory port and fills the IF/ID pipeline register.
// A skid buffer catches a word that returns while decode is stalled. A
// redirect that lands while a fetch is outstanding waits out that fetch in
// DROP and discards its data.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_w_i,
    input  logic        rst_n_w_i,
    input  logic        stall_w_i,
    input  logic        redirect_w_i,
    input  logic [31:0] redirect_pc_w_i,
    output logic        imem_req_w_o,
    output logic [31:0] imem_addr_w_o,
    input  logic [31:0] imem_rdata_w_i,
    input  logic        imem_ack_w_i,
    output logic [31:0] instr_r_o,
    output logic [31:0] pc_r_o,
    output logic        valid_r_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [31:0] r_pc,         w_pc_nxt;
    logic [31:0] r_drop_addr,  w_drop_addr_nxt;
    logic [31:0] r_instr,      w_instr_nxt;
    logic [31:0] r_pc_id,      w_pc_id_nxt;
    logic        r_valid,      w_valid_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_skid_pc,    w_skid_pc_nxt;

    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_pc;

    // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0.
    assign w_pc_inc      = r_pc + 32'd4;
    assign w_redirect_pc = {redirect_pc_w_i[31:2], 2'b00};

    // The bus keeps the abandoned fetch's address while DROP waits for its
    // ack, so the request stays stable even though the PC already holds
    // the redirect target.
    assign imem_req_w_o  = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr_w_o = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign instr_r_o = r_instr;
    assign pc_r_o    = r_pc_id;
    assign valid_r_o = r_valid;

    // Next-state, PC, skid buffer and IF/ID contents; redirect has top priority.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so that no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_addr_nxt  = r_drop_addr;
        w_instr_nxt      = r_instr;
        w_pc_id_nxt      = r_pc_id;
        w_valid_nxt      = r_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (redirect_w_i) begin
            w_pc_nxt         = w_redirect_pc;
            w_instr_nxt      = NOP_INSTR;
            w_pc_id_nxt      = 32'h0;
            w_valid_nxt      = 1'b0;
            w_skid_instr_nxt = NOP_INSTR;
            w_skid_pc_nxt    = 32'h0;
            unique case (r_state)
                S_REQ: begin
                    if (imem_ack_w_i) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt     = S_DROP;
                        w_drop_addr_nxt = r_pc;
                    end
                end
                // A fetch still in flight keeps DROP busy; once its ack is
                // seen the new target can be requested directly.
                S_DROP:  w_state_nxt = imem_ack_w_i ? S_REQ : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_ack_w_i) begin
                        w_pc_nxt = w_pc_inc;
                        if (!stall_w_i) begin
                            w_instr_nxt = imem_rdata_w_i;
                            w_pc_id_nxt = r_pc;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_skid_instr_nxt = imem_rdata_w_i;
                            w_skid_pc_nxt    = r_pc;
                            w_state_nxt      = S_HOLD;
                        end
                    end else if (!stall_w_i) begin
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_w_i) begin
                        w_instr_nxt = r_skid_instr;
                        w_pc_id_nxt = r_skid_pc;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack_w_i) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_w_i) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst_n_w_i) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_pc_id      <= 32'h0;
            r_valid      <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop_addr  <= w_drop_addr_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_id      <= w_pc_id_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

endmodule
